idct_block_scheduler: RTL and testbench

Round-robin scheduler that shares one fully pipelined 8x8 `IDCT` core among `NUM_REQ` block producers. It issues at most one 64-coefficient block per cycle into the core and tracks every in-flight block with a tag pipeline matched to the core latency. Completed blocks go into an output FIFO and are returned with the originating requester's ID. The core has no stall, so issue is credit-gated: no result is ever produced without a free FIFO slot reserved for it.

---
 rtl/idct_block_scheduler.sv | 140 ++++++++++++++
 tb/tb_idct_block_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_block_scheduler.sv
// Round-robin, credit-gated issue of 8x8 blocks into a shared stall-free IDCT core.
// A tag pipeline follows each block through the core into an in-order response FIFO.
module idct_block_scheduler #(
    parameter int NUM_REQ   = 2,
    parameter int LATENCY   = 29,
    parameter int OUT_DEPTH = 4,
    parameter int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*1024-1:0]       req_data,
    output logic [1023:0]                 idct_x,
    input  logic [1023:0]                 idct_out,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [1023:0]                 resp_data,
    output logic [ID_W-1:0]               resp_id,
    output logic [$clog2(LATENCY+2)-1:0]  inflight,
    output logic [15:0]                   blocks_done
);
    localparam int INF_W = $clog2(LATENCY + 2);
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [1023:0]    idct_x_q, idct_x_d;
    tag_t             tag_q [LATENCY+1];
    tag_t             tag_d [LATENCY+1];
    logic [INF_W-1:0] inflight_q, inflight_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      done_q, done_d;
    logic [1023:0]    mem_data_q [OUT_DEPTH];
    logic [ID_W-1:0]  mem_id_q   [OUT_DEPTH];

    logic                   can_issue;
    logic                   accept;
    logic                   push;
    logic                   pop;
    int                     grant_idx;
    logic [2*NUM_REQ-1:0]   rot_valid;
    logic [1023:0]          sel_data;

    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        grant_idx = 0;
        sel_data  = '0;
        // A slot is reserved for every block already in the core or queued; pops this cycle don't count.
        can_issue = (int'(inflight_q) + int'(count_q)) < OUT_DEPTH;
        rot_valid = {req_valid, req_valid} >> rr_ptr_q;
        if (!rst && can_issue) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!accept && rot_valid[i]) begin
                    accept    = 1'b1;
                    grant_idx = (int'(rr_ptr_q) + i) % NUM_REQ;
                end
            end
        end
        if (accept) begin
            req_ready = NUM_REQ'(1) << grant_idx;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == i) sel_data = req_data[i*1024 +: 1024];
        end
    end

    assign resp_valid = (count_q != '0);
    assign push       = tag_q[LATENCY].valid;
    assign pop        = resp_valid && resp_ready;

    // NOTE: combinational next-state logic uses blocking '='; only the always_ff blocks use '<='.
    always_comb begin
        rr_ptr_d   = accept ? ID_W'((grant_idx + 1) % NUM_REQ) : rr_ptr_q;
        idct_x_d   = accept ? sel_data : '0;
        tag_d[0]   = '{valid: accept, id: ID_W'(grant_idx)};
        for (int s = 1; s <= LATENCY; s++) begin
            tag_d[s] = tag_q[s-1];
        end
        inflight_d = inflight_q + INF_W'(accept) - INF_W'(push);
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        done_d     = done_q + 16'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            idct_x_q   <= '0;
            for (int s = 0; s <= LATENCY; s++) begin
                tag_q[s] <= '0;
            end
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            done_q     <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            idct_x_q   <= idct_x_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            done_q     <= done_d;
        end
    end

    // NOTE: FIFO storage has no reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= idct_out;
            mem_id_q[wr_ptr_q]   <= tag_q[LATENCY].id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && count_q == CNT_W'(OUT_DEPTH)));
        end
    end

    assign idct_x      = idct_x_q;
    assign resp_data   = resp_valid ? mem_data_q[rd_ptr_q] : '0;
    assign resp_id     = resp_valid ? mem_id_q[rd_ptr_q] : '0;
    assign inflight    = inflight_q;
    assign blocks_done = done_q;

endmodule

// File: tb/tb_idct_block_scheduler.sv
// Scoreboard bench for idct_block_scheduler: a bench-side core model (delay line with bitwise
// inversion), per-requester source queues, and an expected-response queue with due cycles.
module tb_idct_block_scheduler;
    localparam int N     = 3;
    localparam int LAT   = 29;
    localparam int DEPTH = 32;
    localparam int ID_W  = 2;
    localparam int INF_W = $clog2(LAT + 2);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N*1024-1:0]    req_data;
    logic [1023:0]        idct_x;
    logic [1023:0]        idct_out;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [1023:0]        resp_data;
    logic [ID_W-1:0]      resp_id;
    logic [INF_W-1:0]     inflight;
    logic [15:0]          blocks_done;

    idct_block_scheduler #(
        .NUM_REQ  (N),
        .LATENCY  (LAT),
        .OUT_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .idct_x     (idct_x),
        .idct_out   (idct_out),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .inflight   (inflight),
        .blocks_done(blocks_done)
    );

    always #5 clk = ~clk;

    // Stand-in core: samples idct_x each edge, result valid LAT edges later, never reset.
    logic [1023:0] core_pipe [LAT];
    always @(posedge clk) begin
        core_pipe[0] <= idct_x;
        for (int s = 1; s < LAT; s++) core_pipe[s] <= core_pipe[s-1];
    end
    assign idct_out = ~core_pipe[LAT-1];

    typedef struct {
        logic [ID_W-1:0] id;
        logic [1023:0]   data;
        int              due;
    } exp_t;

    exp_t          exp_q [$];
    logic [1023:0] src_q [N][$];
    int            n_vec = 0;
    int            n_miss = 0;
    int            cyc = 0;
    int            m_rr = 0;
    logic [1023:0] m_x = '0;
    logic [15:0]   m_done = '0;
    bit            hs = 1'b0;
    int            hs_id = 0;
    int            last_acc_edge = 0;
    int            dut_acc = 0;
    int            first_dut_acc = 0;
    int            last_dut_acc = 0;
    int            fill_left = 0;
    bit            rand_ready = 1'b0;

    task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        int lane;
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            lane = 0;
            for (int k = 63; k >= 0; k--) if (got[k*16 +: 16] !== exp[k*16 +: 16]) lane = k;
            $display("FAIL %s @cycle %0d: lane %0d got %h expected %h",
                     tag, cyc, lane, got[lane*16 +: 16], exp[lane*16 +: 16]);
        end
    endtask

    function automatic logic [1023:0] rand_block();
        logic [1023:0] b;
        for (int w = 0; w < 32; w++) b[w*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [1023:0] sparse_block();
        logic [1023:0] b;
        b = '0;
        b[0*16 +: 16]  = -16'sd240;
        b[1*16 +: 16]  = 16'sd8;
        b[2*16 +: 16]  = -16'sd11;
        b[3*16 +: 16]  = 16'sd47;
        b[63*16 +: 16] = -16'sd8;
        return b;
    endfunction

    function automatic bit busy();
        bit b;
        b = (fill_left > 0) || (exp_q.size() > 0);
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                req_valid[i]            = 1'b1;
                req_data[i*1024 +: 1024] = src_q[i][0];
            end else begin
                req_valid[i]            = 1'b0;
                req_data[i*1024 +: 1024] = '0;
            end
        end
    endtask

    // Negedge sampling: compare DUT against the model, then advance the model for the next edge.
    task automatic monitor();
        logic [N-1:0] exp_ready;
        int           g;
        int           n_inf;
        bit           exp_rv;
        exp_ready = '0;
        g = -1;
        if (exp_q.size() < DEPTH) begin
            for (int i = 0; i < N; i++) begin
                if (g < 0 && req_valid[(m_rr + i) % N]) g = (m_rr + i) % N;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", req_ready, exp_ready);
        check("idct_x", idct_x, m_x);
        n_inf = 0;
        foreach (exp_q[k]) if (exp_q[k].due > cyc) n_inf++;
        check("inflight", inflight, n_inf);
        check("blocks_done", blocks_done, m_done);
        exp_rv = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        check("resp_valid", resp_valid, exp_rv);
        if (exp_rv) begin
            check("resp_id", resp_id, exp_q[0].id);
            check("resp_data", resp_data, exp_q[0].data);
            if (resp_ready) begin
                void'(exp_q.pop_front());
                m_done++;
            end
        end
        if (|(req_valid & req_ready)) begin
            dut_acc++;
            if (dut_acc == 1) first_dut_acc = cyc;
            last_dut_acc = cyc;
        end
        hs  = 1'b0;
        m_x = '0;
        if (g >= 0) begin
            hs            = 1'b1;
            hs_id         = g;
            m_rr          = (g + 1) % N;
            last_acc_edge = cyc + 1;
            m_x           = src_q[g][0];
            exp_q.push_back('{id: ID_W'(g), data: ~src_q[g][0], due: cyc + LAT + 2});
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
        if (hs) void'(src_q[hs_id].pop_front());
        for (int i = 0; i < N; i++) begin
            if (fill_left > 0 && src_q[i].size() == 0) begin
                src_q[i].push_back(rand_block());
                fill_left--;
            end
        end
        if (rand_ready) resp_ready = 1'($urandom_range(0, 1));
        drive();
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (busy() && n < budget) begin
            tick();
            n++;
        end
        check("drain_budget", busy(), 0);
    endtask

    task automatic measure_latency(input string tag);
        int n;
        n = 0;
        while (!resp_valid && n < 60) begin
            tick();
            n++;
        end
        check(tag, cyc - last_acc_edge, LAT + 1);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < N; i++) src_q[i].delete();
        fill_left = 0;
        src_q[0].push_back(rand_block());
        drive();
        repeat (cycles) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_inflight", inflight, 0);
        check("rst_blocks_done", blocks_done, 0);
        check("rst_idct_x", idct_x, 0);
        src_q[0].delete();
        drive();
        exp_q.delete();
        m_rr   = 0;
        m_x    = '0;
        m_done = '0;
        hs     = 1'b0;
        rst    = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_rv;
        rst        = 1'b1;
        resp_ready = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        do_reset(3);

        // Single sparse block from requester 0.
        src_q[0].push_back(sparse_block());
        drive();
        measure_latency("t1_latency");
        wait_drain(100);

        // Two requesters streaming: alternating grants, one accept per cycle.
        for (int k = 0; k < 6; k++) begin
            src_q[0].push_back(rand_block());
            src_q[1].push_back(rand_block());
        end
        drive();
        dut_acc = 0;
        wait_drain(200);
        check("t2_accepts", dut_acc, 12);
        check("t2_span", last_dut_acc - first_dut_acc, 11);

        // All requesters with random consumer backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < N; i++) for (int k = 0; k < 8; k++) src_q[i].push_back(rand_block());
        drive();
        wait_drain(2000);
        rand_ready = 1'b0;
        resp_ready = 1'b1;

        // Credit exhaustion with the consumer stalled.
        resp_ready = 1'b0;
        for (int k = 0; k < 40; k++) src_q[0].push_back(rand_block());
        drive();
        dut_acc = 0;
        repeat (80) tick();
        check("t3_accepts", dut_acc, DEPTH);
        check("t3_blocked", req_ready, 0);
        check("t3_inflight", inflight, 0);
        resp_ready = 1'b1;
        wait_drain(300);
        check("t3_total", dut_acc, 40);

        // Round-robin pointer skipping idle requesters and wrapping.
        src_q[0].push_back(rand_block());
        drive();
        #1;
        check("t4_lone_grant", req_ready, 3'b001);
        tick();
        src_q[2].push_back(rand_block());
        drive();
        #1;
        check("t4_skip_grant", req_ready, 3'b100);
        tick();
        src_q[0].push_back(rand_block());
        src_q[1].push_back(rand_block());
        drive();
        #1;
        check("t4_wrap_grant", req_ready, 3'b001);
        wait_drain(100);

        // Reset with blocks still inside the core.
        for (int i = 0; i < N; i++) src_q[i].push_back(rand_block());
        drive();
        repeat (3) tick();
        repeat (10) tick();
        do_reset(1);
        n_rv = 0;
        repeat (40) begin
            tick();
            if (resp_valid) n_rv++;
        end
        check("t5_quiet", n_rv, 0);
        src_q[1].push_back(rand_block());
        drive();
        measure_latency("t5_latency");
        wait_drain(100);

        // 65537 pops from reset: blocks_done wraps to 1.
        do_reset(2);
        resp_ready = 1'b1;
        fill_left  = 65537;
        wait_drain(70000);
        check("t6_wrap", blocks_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
